imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Multicycle fetch sequencer in front of the asynchronous, word-addressed instruction memory (`InstructionMem`: 32-bit byte address in, 32-bit word out after a fixed settle delay). Owns the PC. Drives a stable memory address for a programmable number of settle cycles, then captures the word into the instruction register and hands it to the control FSM. Accepts branch/jump redirects from the datapath at any time.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: full clock cycles the address is held before capture, covering memory settle time; legal range 0–15.
- `RESET_PC`, default 32'h0000_0000: PC after reset; must be word-aligned.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `fetch_req` in 1: control FSM requests the next instruction; level, sampled only in IDLE.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_pc` in 32: redirect target, byte address.
- `mem_addr` out 32: registered byte address to instruction memory.
- `mem_rdata` in 32: instruction word from memory.
- `ir` out 32: instruction register.
- `ir_valid` out 1: one-cycle pulse when `ir` is newly loaded.
- `pc` out 32: address of the instruction in `ir`, or of the next fetch when none is pending.
- `pc_plus4` out 32: `pc + 4`, combinational, modulo 2^32.
- `busy` out 1: FSM not in IDLE.
- `misalign_err` out 1: one-cycle pulse when a redirect is rejected.

## Operation
- States: IDLE, ADDR, WAIT, LATCH.
- IDLE:
  - Stays while `fetch_req`=0.
  - On `fetch_req`=1, goes to ADDR and registers `mem_addr <= pc`.
- ADDR: loads the wait counter with `WAIT_CYCLES`. Goes to WAIT, or straight to LATCH when `WAIT_CYCLES`=0.
- WAIT: decrements the counter and goes to LATCH when it reaches 1.
- LATCH:
  - `ir <= mem_rdata`, `ir_valid` = 1, `pc <= pc + 4`.
  - Returns to IDLE.
  - `pc` wraps from 32'hFFFF_FFFC to 0.
- `mem_addr` is constant from ADDR through LATCH.
- `ir` holds its value until the next LATCH.
- Redirect (any state, highest priority):
  - If `redirect_pc[1:0]`==0: `pc <= redirect_pc` and the in-flight fetch is aborted. The FSM returns to IDLE with no `ir_valid` and `ir` unchanged.
  - If misaligned: redirect ignored, `misalign_err` pulses, state and PC unaffected.
- Redirect and `fetch_req` in the same IDLE cycle: the fetch starts at the redirect target (`mem_addr <= redirect_pc`).
- Redirect in LATCH: the capture is suppressed and the redirect PC wins.
- `fetch_req` outside IDLE is ignored. The requester holds it until `ir_valid`.

## Timing
- Reset values: `pc`=`RESET_PC`, `mem_addr`=`RESET_PC`, `ir`=0, `ir_valid`=0, `busy`=0, `misalign_err`=0, state IDLE, counter 0.
- Latency from `fetch_req` sampled high to `ir_valid` is `WAIT_CYCLES`+2 cycles: 4 at the default, 2 at `WAIT_CYCLES`=0.
- Back-to-back fetches: next ADDR can start the cycle after LATCH if `fetch_req` is still high. Throughput is one instruction per `WAIT_CYCLES`+3 cycles.
- Reset asserted mid-fetch: immediate return to reset values, no `ir_valid`.

## Configuration
- `IMEM_FETCH_PREFETCH_EN` defined:
  - After each LATCH, the FSM immediately fetches `pc` (already incremented) into a one-entry prefetch buffer and sets `pbuf_valid`.
  - `fetch_req` with `pbuf_valid`=1: next cycle `ir <= pbuf`, `ir_valid`, `pc += 4`, and the next prefetch is launched.
  - `fetch_req` during an in-flight prefetch: delivered straight to `ir` at its LATCH.
  - A redirect clears `pbuf_valid` and aborts the prefetch.
- Not defined: fetch happens only on request, as above. No buffer logic is synthesized.

## Structure
- Package `imem_fetch_pkg`:
  - state enum `fetch_state_t`
  - `WORD_BYTES`=4
  - `WAIT_CNT_W`=4
  - default `RESET_PC`
- One sub-module, `fetch_wait_counter`: load, decrement, `done` flag, width `WAIT_CNT_W`. Reused by the prefetch path.

## Test plan
- Reset, then `fetch_req`=1 with memory word 0 = 32'h2008_0005 → `ir_valid` at cycle 4, `ir`=32'h2008_0005, `pc`=4, `mem_addr`=0 stable for cycles 1–4.
- `fetch_req` held high for 3 fetches → `ir_valid` pulses 5 cycles apart, `pc` = 4, 8, 12, `ir` = words 0, 1, 2.
- Redirect to 32'h40 during WAIT → no `ir_valid`, `pc`=32'h40; next fetch reads `mem_addr`=32'h40.
- Redirect to 32'h42 → `misalign_err` pulses one cycle, `pc` and state unchanged, fetch completes normally.
- Redirect to 32'hFFFF_FFFC, then fetch → `pc` wraps to 0 after LATCH; `WAIT_CYCLES`=0 build gives `ir_valid` 2 cycles after request.
- With `IMEM_FETCH_PREFETCH_EN`: after the first fetch, wait 10 cycles, then `fetch_req` → `ir_valid` next cycle with word 1, `pc`=8.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch sequencer.
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LATCH
  } fetch_state_t;

  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned WAIT_CNT_W       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_wait_counter.sv
// Settle-time down counter for the fetch sequencer; done flags the last wait cycle.
module fetch_wait_counter
  import imem_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  dec,
  input  logic [WAIT_CNT_W-1:0] load_val,
  output logic                  done
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WAIT_CNT_W'(1);
    end
  end

  assign done = (count == WAIT_CNT_W'(1));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Multicycle fetch sequencer: owns the PC, holds mem_addr for WAIT_CYCLES settle cycles, then loads ir.
// Defining IMEM_FETCH_PREFETCH_EN adds a one-entry prefetch buffer refilled after every delivery.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        misalign_err
);

  fetch_state_t state, state_next;
  logic         redirect_ok, redirect_bad;
  logic         cnt_load, cnt_dec, cnt_done;
  logic         start, deliver;
  logic [31:0]  start_addr, deliver_word;

  assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign pc_plus4     = pc + 32'(WORD_BYTES);
  assign busy         = (state != S_IDLE);

  fetch_wait_counter u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
    .done     (cnt_done)
  );

`ifdef IMEM_FETCH_PREFETCH_EN
  logic        pbuf_valid, pf_inflight;
  logic [31:0] pbuf;
  logic        to_pbuf, from_pbuf, pf_launch;

  assign deliver_word = from_pbuf ? pbuf : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pbuf_valid  <= 1'b0;
      pbuf        <= '0;
      pf_inflight <= 1'b0;
    end else if (redirect_ok) begin
      pbuf_valid  <= 1'b0;
      pf_inflight <= 1'b0;
    end else begin
      if (start) pf_inflight <= pf_launch;
      if (to_pbuf) begin
        pbuf       <= mem_rdata;
        pbuf_valid <= 1'b1;
      end else if (from_pbuf) begin
        pbuf_valid <= 1'b0;
      end
    end
  end
`else
  assign deliver_word = mem_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_addr = pc;
    deliver    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
`ifdef IMEM_FETCH_PREFETCH_EN
    to_pbuf    = 1'b0;
    from_pbuf  = 1'b0;
    pf_launch  = 1'b0;
`endif
    // An aligned redirect overrides everything; a request in the same IDLE cycle fetches the target.
    if (redirect_ok) begin
      state_next = S_IDLE;
      if ((state == S_IDLE) && fetch_req) begin
        state_next = S_ADDR;
        start      = 1'b1;
        start_addr = redirect_pc;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_req) begin
`ifdef IMEM_FETCH_PREFETCH_EN
            if (pbuf_valid) begin
              from_pbuf  = 1'b1;
              deliver    = 1'b1;
              pf_launch  = 1'b1;
              start_addr = pc_plus4;
            end
`endif
            start      = 1'b1;
            state_next = S_ADDR;
          end
        end
        S_ADDR: begin
          cnt_load   = 1'b1;
          state_next = (WAIT_CYCLES == 0) ? S_LATCH : S_WAIT;
        end
        S_WAIT: begin
          cnt_dec = 1'b1;
          if (cnt_done) state_next = S_LATCH;
        end
        S_LATCH: begin
`ifdef IMEM_FETCH_PREFETCH_EN
          // A prefetch nobody is waiting for parks in the buffer; otherwise deliver and refill.
          if (pf_inflight && !fetch_req) begin
            to_pbuf    = 1'b1;
            state_next = S_IDLE;
          end else begin
            deliver    = 1'b1;
            start      = 1'b1;
            pf_launch  = 1'b1;
            start_addr = pc_plus4;
            state_next = S_ADDR;
          end
`else
          deliver    = 1'b1;
          state_next = S_IDLE;
`endif
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      mem_addr     <= RESET_PC;
      ir           <= '0;
      ir_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      ir_valid     <= deliver;
      misalign_err <= redirect_bad;
      if (redirect_ok)  pc <= redirect_pc;
      else if (deliver) pc <= pc_plus4;
      if (start)   mem_addr <= start_addr;
      if (deliver) ir <= deliver_word;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances share one stimulus stream.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] maddr;
    logic [31:0] ir;
    bit          busy;
    int unsigned done_at;
  } mdl_t;

  typedef struct {
    logic        iv;
    logic        mis;
    logic        busy;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] maddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] maddr0, rdata0, ir0, pc0, pcp0;
  logic        iv0, busy0, mis0;
  logic [31:0] maddr1, rdata1, ir1, pc1, pcp1;
  logic        iv1, busy1, mis1;

  int          checks = 0;
  int          failures = 0;
  int unsigned n = 0;
  bit          mon_en = 1'b0;
  mdl_t        m0, m1;
  exp_t        q0[$], q1[$];
  exp_t        e_mon0, e_mon1;
  logic        rf, rr;
  logic [31:0] rp;

  // Asynchronous memory: word content is a fixed function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 ^ (a * 32'h0001_0003);
  endfunction

  assign rdata0 = mem_word(maddr0);
  assign rdata1 = mem_word(maddr1);

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.WAIT_CYCLES(2), .RESET_PC(RST_PC)) dut_w2 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(maddr0), .mem_rdata(rdata0), .ir(ir0), .ir_valid(iv0),
    .pc(pc0), .pc_plus4(pcp0), .busy(busy0), .misalign_err(mis0)
  );

  imem_fetch_ctrl #(.WAIT_CYCLES(0), .RESET_PC(RST_PC)) dut_w0 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(maddr1), .mem_rdata(rdata1), .ir(ir1), .ir_valid(iv1),
    .pc(pc1), .pc_plus4(pcp1), .busy(busy1), .misalign_err(mis1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a request accepted at edge s completes at edge s+W+2 unless redirected.
  task automatic model_step(input int unsigned w, inout mdl_t m, output exp_t e);
    e.iv  = 1'b0;
    e.mis = 1'b0;
    if (redirect_valid && (redirect_pc % 4 == 0)) begin
      m.pc = redirect_pc;
      if (!m.busy && fetch_req) begin
        m.busy = 1'b1; m.maddr = redirect_pc; m.done_at = n + w + 2;
      end else begin
        m.busy = 1'b0;
      end
    end else begin
      e.mis = redirect_valid;
      if (!m.busy) begin
        if (fetch_req) begin
          m.busy = 1'b1; m.maddr = m.pc; m.done_at = n + w + 2;
        end
      end else if (n == m.done_at) begin
        m.ir   = mem_word(m.maddr);
        e.iv   = 1'b1;
        m.pc   = m.pc + 32'd4;
        m.busy = 1'b0;
      end
    end
    e.busy  = m.busy;
    e.ir    = m.ir;
    e.pc    = m.pc;
    e.maddr = m.maddr;
  endtask

  task automatic model_init(output mdl_t m);
    m.pc = RST_PC; m.maddr = RST_PC; m.ir = '0; m.busy = 1'b0; m.done_at = 0;
  endtask

  task automatic check_dut(input int unsigned w, input exp_t e,
                           input logic [31:0] a_ir, input logic [31:0] a_pc,
                           input logic [31:0] a_pcp, input logic [31:0] a_maddr,
                           input logic a_iv, input logic a_busy, input logic a_mis);
    chk($sformatf("ir_valid_w%0d", w), 32'(a_iv), 32'(e.iv));
    chk($sformatf("ir_w%0d", w), a_ir, e.ir);
    chk($sformatf("pc_w%0d", w), a_pc, e.pc);
    chk($sformatf("pc_plus4_w%0d", w), a_pcp, e.pc + 32'd4);
    chk($sformatf("mem_addr_w%0d", w), a_maddr, e.maddr);
    chk($sformatf("busy_w%0d", w), 32'(a_busy), 32'(e.busy));
    chk($sformatf("misalign_err_w%0d", w), 32'(a_mis), 32'(e.mis));
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_empty_w2 actual=0 entries expected=1");
      end else begin
        e_mon0 = q0.pop_front();
        check_dut(2, e_mon0, ir0, pc0, pcp0, maddr0, iv0, busy0, mis0);
      end
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_empty_w0 actual=0 entries expected=1");
      end else begin
        e_mon1 = q1.pop_front();
        check_dut(0, e_mon1, ir1, pc1, pcp1, maddr1, iv1, busy1, mis1);
      end
    end
  end

  task automatic cyc(input logic f, input logic r, input logic [31:0] p);
    exp_t e;
    fetch_req = f; redirect_valid = r; redirect_pc = p;
    n++;
    model_step(2, m0, e); q0.push_back(e);
    model_step(0, m1, e); q1.push_back(e);
    @(negedge clk);
  endtask

  // Called on a negedge; reset takes effect immediately, without waiting for a clock.
  task automatic do_reset();
    mon_en = 1'b0;
    fetch_req = 1'b0; redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_pc_w2", pc0, RST_PC);          chk("rst_pc_w0", pc1, RST_PC);
    chk("rst_mem_addr_w2", maddr0, RST_PC); chk("rst_mem_addr_w0", maddr1, RST_PC);
    chk("rst_ir_w2", ir0, '0);              chk("rst_ir_w0", ir1, '0);
    chk("rst_ir_valid_w2", 32'(iv0), '0);   chk("rst_ir_valid_w0", 32'(iv1), '0);
    chk("rst_busy_w2", 32'(busy0), '0);     chk("rst_busy_w0", 32'(busy1), '0);
    chk("rst_mis_w2", 32'(mis0), '0);       chk("rst_mis_w0", 32'(mis1), '0);
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    model_init(m0);
    model_init(m1);
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Three back-to-back fetches with fetch_req held high.
    repeat (15) cyc(1'b1, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b0, '0);

    // Aligned redirect to 0x40 while the W=2 fetch is waiting, then fetch from the target.
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'h0000_0040);
    repeat (3) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    repeat (6) cyc(1'b0, 1'b0, '0);

    // Misaligned redirect mid-fetch is ignored.
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'h0000_0042);
    repeat (6) cyc(1'b0, 1'b0, '0);

    // Redirect to the top word, then fetch: pc wraps to zero.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, '0);
    repeat (6) cyc(1'b0, 1'b0, '0);

    // Redirect and request in the same idle cycle.
    cyc(1'b1, 1'b1, 32'h0000_0100);
    repeat (6) cyc(1'b0, 1'b0, '0);

    // Reset in the middle of a fetch.
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      rf = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 11) == 0);
      rp = 32'($urandom_range(0, 255)) << 2;
      case ($urandom_range(0, 5))
        0: rp = 32'hFFFF_FFFC;
        1: rp = rp | 32'($urandom_range(1, 3));
        default: ;
      endcase
      if (i == 700) do_reset();
      cyc(rf, rr, rp);
    end
    repeat (2) cyc(1'b0, 1'b0, '0);

    chk("sb_drain_w2", 32'(q0.size()), '0);
    chk("sb_drain_w0", 32'(q1.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
